// File: rtl/shiftreg_tx_sched.sv
// shiftreg_tx_sched: round-robin transmit scheduler for an 8-bit MSB-first
// parallel-load shift register. It arbitrates two valid/ready byte sources,
// drives the register's load/fill inputs and frames the eight serial bits.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no frame in flight; the winner of a request is accepted here
//   SHIFT | a data bit is on the serial output, cnt 0..7 (bit 7-cnt)
//   GAP   | idle spacing after the last bit, IDLE_GAP cycles long
module shiftreg_tx_sched #(
    parameter int unsigned IDLE_GAP = 1,
    parameter logic        FILL_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_data,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_data,
    output logic       o_req1_ready,
    output logic [7:0] o_sr_wr_data,
    output logic       o_sr_wr_data_en,
    output logic       o_sr_wr_bit,
    output logic       o_frame,
    output logic [2:0] o_bit_idx,
    output logic       o_frame_last,
    output logic       o_frame_id,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // GAP counts down from IDLE_GAP-1 to 0, giving exactly IDLE_GAP cycles.
    localparam bit          HAS_GAP  = (IDLE_GAP != 0);
    localparam int unsigned GAP_M1   = HAS_GAP ? (IDLE_GAP - 1) : 0;
    localparam logic [3:0]  GAP_LOAD = GAP_M1[3:0];

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [3:0] gap_cnt;
    logic       last_grant;
    logic       frame_id;

    logic       winner;
    logic       accept;
    logic       handshake;

    // Round-robin winner selection and the combinational ready/handshake.
    always_comb begin
        winner = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            winner = ~last_grant;
        end else if (i_req1_valid) begin
            winner = 1'b1;
        end
        // With no gap the next byte may load on the last bit, giving no bubble.
        accept       = (state == IDLE) ||
                       ((state == SHIFT) && (cnt == 3'd7) && !HAS_GAP);
        o_req0_ready = accept && i_req0_valid && !winner;
        o_req1_ready = accept && i_req1_valid && winner;
        handshake    = o_req0_ready || o_req1_ready;
    end

    // State register plus bit counter, gap down-counter, pointer and frame owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            gap_cnt    <= 4'd0;
            last_grant <= 1'b1;
            frame_id   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                cnt        <= 3'd0;
                last_grant <= winner;
                frame_id   <= winner;
            end else if (state == SHIFT) begin
                cnt <= cnt + 3'd1;
            end
            if ((state == SHIFT) && (state_nxt == GAP)) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == GAP) && (gap_cnt != 4'd0)) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (handshake) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == 3'd7) begin
                    if (handshake)    state_nxt = SHIFT;
                    else if (HAS_GAP) state_nxt = GAP;
                    else              state_nxt = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: load strobe/data from the handshake, framing from the state.
    always_comb begin
        o_sr_wr_data_en = handshake;
        o_sr_wr_data    = 8'h00;
        if (handshake) begin
            o_sr_wr_data = winner ? i_req1_data : i_req0_data;
        end
        o_sr_wr_bit  = FILL_BIT;
        o_frame      = (state == SHIFT);
        o_bit_idx    = (state == SHIFT) ? (3'd7 - cnt) : 3'd0;
        o_frame_last = (state == SHIFT) && (cnt == 3'd7);
        o_frame_id   = frame_id;
        o_busy       = (state != IDLE);
    end

endmodule

// File: tb/tb_shiftreg_tx_sched.sv
// Bench for shiftreg_tx_sched: three instances (IDLE_GAP 1/0/15, FILL_BIT
// 0/1/0) each driving a small MSB-first shift register model. Expected
// frames are queued at each handshake and popped when the frame's last bit
// appears on the serial output of the selected instance.
module tb_shiftreg_tx_sched;

    logic       clk;
    logic       rst_n;
    logic [2:0] v0;
    logic [2:0] v1;
    logic [7:0] d0 [3];
    logic [7:0] d1 [3];
    wire  [2:0] rdy0, rdy1, wr_en, wr_bit, frame, last, fid, busy, ser;
    wire  [7:0] wr_data [3];
    wire  [2:0] bit_idx [3];

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int unsigned GAP = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
        logic [7:0] sr;

        shiftreg_tx_sched #(.IDLE_GAP(GAP), .FILL_BIT(g == 1)) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_req0_valid   (v0[g]),
            .i_req0_data    (d0[g]),
            .o_req0_ready   (rdy0[g]),
            .i_req1_valid   (v1[g]),
            .i_req1_data    (d1[g]),
            .o_req1_ready   (rdy1[g]),
            .o_sr_wr_data   (wr_data[g]),
            .o_sr_wr_data_en(wr_en[g]),
            .o_sr_wr_bit    (wr_bit[g]),
            .o_frame        (frame[g]),
            .o_bit_idx      (bit_idx[g]),
            .o_frame_last   (last[g]),
            .o_frame_id     (fid[g]),
            .o_busy         (busy[g])
        );

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n)        sr <= 8'h00;
            else if (wr_en[g]) sr <= wr_data[g];
            else               sr <= {sr[6:0], wr_bit[g]};
        end
        assign ser[g] = sr[7];
    end

    typedef struct {
        bit         id;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         errors = 0;
    int         checks = 0;
    int         sel = 0;
    int         cyc = 0;
    int         pos = 0;
    int         run_cur = 0, run_max = 0, gap_cur = 0, gap_last = 0;
    logic [7:0] acc = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Serial-side monitor for the selected instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            pos = 0; run_cur = 0; gap_cur = 0;
        end else begin
            if (frame[sel]) begin
                chk("bit_idx", bit_idx[sel], 7 - pos);
                chk("frame_last", last[sel], (pos == 7) ? 1 : 0);
                acc = {acc[6:0], ser[sel]};
                if (pos == 7) begin
                    if (q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("frame_data", acc, e.data);
                        chk("frame_id", fid[sel], e.id);
                    end
                    pos = 0;
                end else begin
                    pos++;
                end
                run_cur++;
                if (run_cur > run_max) run_max = run_cur;
            end else begin
                run_cur = 0;
            end
            if (busy[sel] && !frame[sel]) begin
                gap_cur++;
            end else begin
                if (gap_cur > 0) gap_last = gap_cur;
                gap_cur = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = '0;
        v1 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_max = 0;
        gap_last = 0;
    endtask

    task automatic wait_hs(input bit eid, input logic [7:0] edata, output int at);
        bit done;
        done = 1'b0;
        at = -1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if ((v0[sel] && rdy0[sel]) || (v1[sel] && rdy1[sel])) begin
                chk("grant_id", rdy1[sel] ? 1 : 0, eid);
                chk("one_ready", rdy0[sel] & rdy1[sel], 0);
                chk("load_en", wr_en[sel], 1);
                chk("load_data", wr_data[sel], edata);
                q.push_back('{eid, edata});
                at = cyc;
                done = 1'b1;
            end else begin
                chk("noload_en", wr_en[sel], 0);
                chk("noload_data", wr_data[sel], 0);
            end
        end
        if (!done) chk("hs_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!busy[sel]) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int t1, t2;
        bit found;
        rst_n = 1'b0;
        v0 = '0;
        v1 = '0;
        for (int i = 0; i < 3; i++) begin
            d0[i] = 8'h00;
            d1[i] = 8'h00;
        end

        // Reset state
        sel = 0;
        do_reset();
        @(negedge clk);
        chk("rst_frame", frame[0], 0);
        chk("rst_bit_idx", bit_idx[0], 0);
        chk("rst_last", last[0], 0);
        chk("rst_id", fid[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_ready0", rdy0[0], 0);
        chk("rst_wr_en", wr_en[0], 0);
        chk("rst_wr_data", wr_data[0], 0);
        chk("fill_bit0", wr_bit[0], 0);
        chk("fill_bit1", wr_bit[1], 1);
        step();

        // Single byte, IDLE_GAP=1: next ready at T+10
        v0[0] = 1'b1; d0[0] = 8'hA5;
        wait_hs(0, 8'hA5, t1);
        step();
        d0[0] = 8'h3C;
        wait_hs(0, 8'h3C, t2);
        chk("gap1_ready_latency", t2 - t1, 10);
        step();
        v0[0] = 1'b0;
        chk("gap1_len", gap_last, 1);
        wait_idle();
        step();

        // Contention: grants alternate 0,1,0,1
        do_reset();
        v0[0] = 1'b1; d0[0] = 8'h11;
        v1[0] = 1'b1; d1[0] = 8'h22;
        for (int k = 0; k < 4; k++) begin
            wait_hs(k[0], k[0] ? 8'h22 : 8'h11, t1);
            step();
        end
        v0[0] = 1'b0; v1[0] = 1'b0;
        wait_idle();
        step();

        // Back-to-back, IDLE_GAP=0, fill bit 1
        sel = 1;
        do_reset();
        v1[1] = 1'b1; d1[1] = 8'hFF;
        wait_hs(1, 8'hFF, t1);
        step();
        d1[1] = 8'h00;
        wait_hs(1, 8'h00, t2);
        chk("b2b_hs_at_last", last[1], 1);
        chk("b2b_latency", t2 - t1, 8);
        step();
        v1[1] = 1'b0;
        wait_idle();
        chk("b2b_run", run_max, 16);
        for (int k = 0; k < 3; k++) begin
            chk("fill_idle", ser[1], 1);
            @(negedge clk);
        end
        step();

        // Gap length 15
        sel = 2;
        do_reset();
        v0[2] = 1'b1; d0[2] = 8'h5A;
        wait_hs(0, 8'h5A, t1);
        step();
        d0[2] = 8'hC3;
        wait_hs(0, 8'hC3, t2);
        chk("gap15_latency", t2 - t1, 24);
        chk("gap15_idle_at_hs", busy[2], 0);
        step();
        v0[2] = 1'b0;
        chk("gap15_len", gap_last, 15);
        wait_idle();
        step();

        // Reset mid-frame
        sel = 0;
        do_reset();
        v0[0] = 1'b1; d0[0] = 8'h96;
        wait_hs(0, 8'h96, t1);
        step();
        v0[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (frame[0] && bit_idx[0] == 3'd4) found = 1'b1;
        end
        chk("midreset_reach_idx4", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_frame", frame[0], 0);
        chk("midreset_busy", busy[0], 0);
        chk("midreset_idx", bit_idx[0], 0);
        if (q.size() > 0) void'(q.pop_back());
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        v0[0] = 1'b1; d0[0] = 8'h77;
        v1[0] = 1'b1; d1[0] = 8'h88;
        wait_hs(0, 8'h77, t1);
        step();
        wait_hs(1, 8'h88, t2);
        step();
        v0[0] = 1'b0; v1[0] = 1'b0;
        wait_idle();
        repeat (3) step();

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
